// File: rtl/instr_encoder.sv
// RV32I instruction encoder: decodes an abstract op/register/immediate request,
// range-checks it, and queues the encoded word with its byte address in a 2-entry FIFO.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_op,
    output logic        err_imm,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } entry_t;

    fmt_t        fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        op_ok;
    logic        imm_ok;
    logic [31:0] enc;

    entry_t      mem [2];
    logic        wr_ptr, rd_ptr;
    logic [1:0]  count;
    logic [31:0] addr;
    logic        full, accept, push, pop;

    always_comb begin
        fmt   = FMT_R;
        opc   = 7'b0110011;
        f3    = 3'b000;
        f7    = 7'b0000000;
        op_ok = 1'b1;
        case (in_op)
            5'd0:  ;
            5'd1:  f7 = 7'b0100000;
            5'd2:  f3 = 3'b001;
            5'd3:  f3 = 3'b101;
            5'd4:  begin f3 = 3'b101; f7 = 7'b0100000; end
            5'd5:  f3 = 3'b010;
            5'd6:  f3 = 3'b011;
            5'd7:  f3 = 3'b111;
            5'd8:  f3 = 3'b110;
            5'd9:  begin fmt = FMT_I; opc = 7'b0010011; end
            5'd10: begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b111; end
            5'd11: begin fmt = FMT_I; opc = 7'b0010011; f3 = 3'b110; end
            5'd12: begin fmt = FMT_I; opc = 7'b0000011; f3 = 3'b010; end
            5'd13: begin fmt = FMT_S; opc = 7'b0100011; f3 = 3'b010; end
            5'd14: begin fmt = FMT_B; opc = 7'b1100011; end
            5'd15: begin fmt = FMT_J; opc = 7'b1101111; end
            5'd16: begin fmt = FMT_I; opc = 7'b1100111; end
            5'd17: begin fmt = FMT_U; opc = 7'b0110111; end
            5'd18: begin fmt = FMT_U; opc = 7'b0010111; end
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = ($signed(in_imm) >= -32'sd2048) && ($signed(in_imm) <= 32'sd2047);
            FMT_B: imm_ok = ($signed(in_imm) >= -32'sd4096) && ($signed(in_imm) <= 32'sd4094) && !in_imm[0];
            FMT_J: imm_ok = ($signed(in_imm) >= -32'sd1048576) && ($signed(in_imm) <= 32'sd1048574) && !in_imm[0];
            FMT_U: imm_ok = (in_imm[11:0] == 12'd0);
            default: imm_ok = 1'b1;
        endcase
    end

    always_comb begin
        enc = 32'd0;
        case (fmt)
            FMT_R: enc = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            FMT_I: enc = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            FMT_S: enc = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            FMT_B: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3, in_imm[4:1], in_imm[11], opc};
            FMT_U: enc = {in_imm[31:12], in_rd, opc};
            FMT_J: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opc};
            default: enc = 32'd0;
        endcase
    end

    // No bypass: a full FIFO refuses input even while it is being drained.
    assign full      = (count == 2'd2);
    assign in_ready  = rst_n && !full && !clear;
    assign accept    = in_valid && in_ready;
    assign push      = accept && op_ok && imm_ok;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    assign out_instr = out_valid ? mem[rd_ptr].instr : 32'd0;
    assign out_addr  = out_valid ? mem[rd_ptr].addr  : 32'd0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{instr: enc, addr: addr};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            addr        <= 32'd0;
            instr_count <= 16'd0;
            err_op      <= 1'b0;
            err_imm     <= 1'b0;
        end else if (clear) begin
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            addr        <= 32'd0;
            instr_count <= 16'd0;
            err_op      <= 1'b0;
            err_imm     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr      <= ~wr_ptr;
                addr        <= addr + 32'd4;
                instr_count <= instr_count + 16'd1;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
            if (accept && !op_ok) err_op <= 1'b1;
            if (accept && op_ok && !imm_ok) err_imm <= 1'b1;
        end
    end

endmodule
